// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer
//   Game-flow controller for a snake game: menu -> stage banner -> wait for
//   first key -> play -> game over -> menu. It also provides a free-running
//   frame tick, a snake-move pulse at the selected speed, and the apple score.
//
// Ports
//   clk              in   system clock, all state on the rising edge
//   reset            in   asynchronous, active-high reset
//   num_1/2/3        in   difficulty select in the menu (num_1 highest priority)
//   esc              in   abort back to the menu from any other state
//   key_touched      in   any direction key pressed (starts play)
//   good_collision   in   snake head on an apple this cycle
//   bad_collision    in   snake head on a wall/body this cycle
//   inmenu/stage_show/ingame/game_over  out  one-hot state indicators
//   step             out  one-cycle move pulse, coincident with frame_tick
//   frame_tick       out  one-cycle pulse per frame
//   main_difficulty  out  move period in frames (10, 3 or 1)
//   score            out  apples eaten this game, saturating at 255
module snake_game_sequencer #(
  parameter int FRAME_DIV   = 840000,
  parameter int SHOW_FRAMES = 120,
  parameter int OVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       num_1,
  input  logic       num_2,
  input  logic       num_3,
  input  logic       esc,
  input  logic       key_touched,
  input  logic       good_collision,
  input  logic       bad_collision,
  output logic       inmenu,
  output logic       ingame,
  output logic       game_over,
  output logic       stage_show,
  output logic       step,
  output logic       frame_tick,
  output logic [3:0] main_difficulty,
  output logic [7:0] score
);

  localparam int CNT_W   = $clog2(FRAME_DIV);
  localparam int TMR_MAX = (SHOW_FRAMES > OVER_FRAMES) ? SHOW_FRAMES : OVER_FRAMES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_DIV - 1);
  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_FRAMES - 1);
  localparam logic [TMR_W-1:0] OVER_LAST = TMR_W'(OVER_FRAMES - 1);

  typedef enum logic [2:0] {
    S_MENU,
    S_STAGE,
    S_WAIT,
    S_INGAME,
    S_OVER
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [TMR_W-1:0] r_timer;
  logic [3:0]       r_step_cnt;
  logic [3:0]       r_difficulty;
  logic [7:0]       r_score;
  logic             r_frame_tick;
  logic             r_step;
  logic             r_inmenu;
  logic             r_stage_show;
  logic             r_ingame;
  logic             r_game_over;

  logic             w_tick_next;
  logic             w_any_num;
  logic [3:0]       w_step_base;
  logic [3:0]       w_step_inc;

  // frame_tick is registered, so the tick that will be visible next cycle is
  // decided now; step uses the same look-ahead so both pulses line up.
  assign w_tick_next = (r_frame_cnt == CNT_LAST);
  assign w_any_num   = num_1 | num_2 | num_3;

  // Timers count frame_tick cycles seen while in the state, so the state
  // changes on the edge that samples the last required tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MENU: begin
        if (w_any_num) w_next = S_STAGE;
      end
      S_STAGE: begin
        if (esc)                                    w_next = S_MENU;
        else if (r_frame_tick && r_timer == SHOW_LAST) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (esc)              w_next = S_MENU;
        else if (key_touched) w_next = S_INGAME;
      end
      S_INGAME: begin
        if (esc)                w_next = S_MENU;
        else if (bad_collision) w_next = S_OVER;
      end
      S_OVER: begin
        if (esc)                                    w_next = S_MENU;
        else if (r_frame_tick && r_timer == OVER_LAST) w_next = S_MENU;
      end
      default: w_next = S_MENU;
    endcase
  end

  // Move counter restarts from zero when play begins.
  always_comb begin
    w_step_base = (r_state == S_INGAME) ? r_step_cnt : 4'd0;
    w_step_inc  = w_step_base + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_MENU;
      r_frame_cnt  <= '0;
      r_frame_tick <= 1'b0;
      r_timer      <= '0;
      r_step_cnt   <= 4'd0;
      r_step       <= 1'b0;
      r_difficulty <= 4'd1;
      r_score      <= 8'd0;
      r_inmenu     <= 1'b1;
      r_stage_show <= 1'b0;
      r_ingame     <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_frame_cnt  <= w_tick_next ? '0 : r_frame_cnt + 1'b1;
      r_frame_tick <= w_tick_next;

      r_state      <= w_next;
      r_inmenu     <= (w_next == S_MENU);
      r_stage_show <= (w_next == S_STAGE);
      r_ingame     <= (w_next == S_INGAME);
      r_game_over  <= (w_next == S_OVER);

      if (w_next != r_state)
        r_timer <= '0;
      else if (r_frame_tick && (r_state == S_STAGE || r_state == S_OVER))
        r_timer <= r_timer + 1'b1;

      // Only a selection made while in the menu is captured.
      if (r_state == S_MENU && w_any_num)
        r_difficulty <= num_1 ? 4'd10 : (num_2 ? 4'd3 : 4'd1);

      if (w_next == S_STAGE && r_state != S_STAGE)
        r_score <= 8'd0;
      else if (r_state == S_INGAME && good_collision && !bad_collision && r_score != 8'd255)
        r_score <= r_score + 8'd1;

      // Leaving play (bad collision or esc) suppresses the pulse that cycle.
      if (w_next == S_INGAME) begin
        if (w_tick_next) begin
          if (w_step_inc == r_difficulty) begin
            r_step     <= 1'b1;
            r_step_cnt <= 4'd0;
          end else begin
            r_step     <= 1'b0;
            r_step_cnt <= w_step_inc;
          end
        end else begin
          r_step     <= 1'b0;
          r_step_cnt <= w_step_base;
        end
      end else begin
        r_step     <= 1'b0;
        r_step_cnt <= 4'd0;
      end
    end
  end

  assign inmenu          = r_inmenu;
  assign stage_show      = r_stage_show;
  assign ingame          = r_ingame;
  assign game_over       = r_game_over;
  assign step            = r_step;
  assign frame_tick      = r_frame_tick;
  assign main_difficulty = r_difficulty;
  assign score           = r_score;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Testbench for snake_game_sequencer with small frame parameters.
// Stimulus drives inputs on the falling edge and pushes the expected output
// set for the next output event (rising clk or rising reset) into a queue;
// an independent monitor pops and compares on each such event.
module tb_snake_game_sequencer;

  localparam int FD = 4;
  localparam int SF = 2;
  localparam int OF = 3;

  localparam int M_MENU   = 0;
  localparam int M_STAGE  = 1;
  localparam int M_WAIT   = 2;
  localparam int M_INGAME = 3;
  localparam int M_OVER   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       num_1 = 1'b0, num_2 = 1'b0, num_3 = 1'b0;
  logic       esc = 1'b0, key_touched = 1'b0;
  logic       good_collision = 1'b0, bad_collision = 1'b0;
  logic       inmenu, ingame, game_over, stage_show, step, frame_tick;
  logic [3:0] main_difficulty;
  logic [7:0] score;

  snake_game_sequencer #(
    .FRAME_DIV  (FD),
    .SHOW_FRAMES(SF),
    .OVER_FRAMES(OF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .num_1          (num_1),
    .num_2          (num_2),
    .num_3          (num_3),
    .esc            (esc),
    .key_touched    (key_touched),
    .good_collision (good_collision),
    .bad_collision  (bad_collision),
    .inmenu         (inmenu),
    .ingame         (ingame),
    .game_over      (game_over),
    .stage_show     (stage_show),
    .step           (step),
    .frame_tick     (frame_tick),
    .main_difficulty(main_difficulty),
    .score          (score)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       menu;
    logic       stage;
    logic       play;
    logic       over;
    logic       stp;
    logic       tick;
    logic [3:0] diff;
    logic [7:0] scr;
  } obs_t;

  obs_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: game state, edges since reset, frame ticks seen in the
  // current state, score, difficulty, and the current tick/step outputs.
  int m_state, m_k, m_ticks_in_state, m_score, m_diff;
  bit m_tick, m_step;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  function automatic obs_t m_obs();
    obs_t o;
    o.menu  = (m_state == M_MENU);
    o.stage = (m_state == M_STAGE);
    o.play  = (m_state == M_INGAME);
    o.over  = (m_state == M_OVER);
    o.stp   = m_step;
    o.tick  = m_tick;
    o.diff  = 4'(m_diff);
    o.scr   = 8'(m_score);
    return o;
  endfunction

  task automatic m_reset();
    m_state = M_MENU; m_k = 0; m_ticks_in_state = 0;
    m_score = 0; m_diff = 1; m_tick = 0; m_step = 0;
  endtask

  task automatic m_edge(input bit n1, n2, n3, e, key, good, bad);
    int ns, seen;
    bit t_new;
    seen = m_ticks_in_state + (m_tick ? 1 : 0);
    ns   = m_state;
    case (m_state)
      M_MENU:   if (n1 || n2 || n3) ns = M_STAGE;
      M_STAGE:  if (e) ns = M_MENU; else if (seen == SF) ns = M_WAIT;
      M_WAIT:   if (e) ns = M_MENU; else if (key) ns = M_INGAME;
      M_INGAME: if (e) ns = M_MENU; else if (bad) ns = M_OVER;
      M_OVER:   if (e) ns = M_MENU; else if (seen == OF) ns = M_MENU;
      default:  ns = M_MENU;
    endcase
    if (m_state == M_MENU && (n1 || n2 || n3)) m_diff = n1 ? 10 : (n2 ? 3 : 1);
    if (ns == M_STAGE && m_state != M_STAGE) m_score = 0;
    else if (m_state == M_INGAME && good && !bad && m_score < 255) m_score++;
    m_k++;
    t_new = (m_k % FD == 0);
    m_ticks_in_state = (ns != m_state) ? 0 : seen;
    // A move happens on every diff-th frame tick counted since play began.
    m_step = (ns == M_INGAME) && t_new &&
             (((m_ticks_in_state + 1) % m_diff) == 0);
    m_tick  = t_new;
    m_state = ns;
  endtask

  task automatic drive(input bit r, n1, n2, n3, e, key, good, bad);
    @(negedge clk);
    num_1 = n1; num_2 = n2; num_3 = n3; esc = e; key_touched = key;
    good_collision = good; bad_collision = bad;
    if (r) begin
      if (!reset) begin
        m_reset();
        q.push_back(m_obs());
        reset = 1'b1;
      end
      q.push_back(m_obs());
    end else begin
      reset = 1'b0;
      m_edge(n1, n2, n3, e, key, good, bad);
      q.push_back(m_obs());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expectation per rising clk or rising reset.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (q.size() == 0) begin
        chk("expectation_available", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("inmenu",          32'(inmenu),          32'(e.menu));
        chk("stage_show",      32'(stage_show),      32'(e.stage));
        chk("ingame",          32'(ingame),          32'(e.play));
        chk("game_over",       32'(game_over),       32'(e.over));
        chk("step",            32'(step),            32'(e.stp));
        chk("frame_tick",      32'(frame_tick),      32'(e.tick));
        chk("main_difficulty", 32'(main_difficulty), 32'(e.diff));
        chk("score",           32'(score),           32'(e.scr));
      end
    end
  end

  initial begin
    bit r, n1, n2, n3, e, key, good, bad;
    #2;
    m_reset();
    q.push_back(m_obs());
    reset = 1'b1;
    q.push_back(m_obs());
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // difficulty 3, banner, wait, play with step every third tick
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    idle(12);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(40);
    // score saturation, then good+bad together, then auto-return
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    idle(20);

    // num_1 beats num_3; esc from the banner; num held past menu exit
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);

    // asynchronous reset in the middle of a game with score 5
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(12);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // randomized play
    for (int i = 0; i < 20000; i++) begin
      r    = ($urandom_range(0, 1999) == 0);
      n1   = ($urandom_range(0, 9) == 0);
      n2   = ($urandom_range(0, 9) == 0);
      n3   = ($urandom_range(0, 9) == 0);
      e    = ($urandom_range(0, 99) == 0);
      key  = ($urandom_range(0, 3) == 0);
      good = ($urandom_range(0, 2) == 0);
      bad  = ($urandom_range(0, 39) == 0);
      drive(r, n1, n2, n3, e, key, good, bad);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_game_sequencer.md
SNAKE_GAME_SEQUENCER -- requirements
Module: snake_game_sequencer

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 840000: clk cycles per frame tick (>=2).
REQ-002 SHALL have parameter SHOW_FRAMES, default 120: frames spent in STAGE_DISPLAY (>=1).
REQ-003 SHALL have parameter OVER_FRAMES, default 180: frames spent in GAME_OVER before auto-return (>=1).
REQ-004 SHALL have port clk  in  1  system clock, 50 MHz; one clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports num_1, num_2, num_3  in  1 each  difficulty select, active-high level.
REQ-007 SHALL have port esc  in  1  abort to menu, active-high level.
REQ-008 SHALL have port key_touched  in  1  any direction key pressed, active-high level.
REQ-009 SHALL have ports good_collision, bad_collision  in  1 each  datapath collision flags, sampled each clk.
REQ-010 SHALL have ports inmenu, ingame, game_over, stage_show  out  1 each  one-hot state indicators.
REQ-011 SHALL have port step  out  1  one-cycle snake-move pulse.
REQ-012 SHALL have port frame_tick  out  1  one-cycle pulse per frame.
REQ-013 SHALL have port main_difficulty  out  4  step period in frames (10, 3 or 1).
REQ-014 SHALL have port score  out  8  apples eaten this game.

Function
REQ-015 SHALL implement states MENU, STAGE_DISPLAY, GAME_WAIT, INGAME, GAME_OVER; all outputs registered.
REQ-016 SHALL run frame counter 0..FRAME_DIV-1, wrapping; frame_tick=1 for the cycle after count reaches FRAME_DIV-1; free-running in all states.
REQ-017 MENU: any num_x high -> STAGE_DISPLAY next cycle; main_difficulty latched same edge: num_1 -> 10, else num_2 -> 3, else num_3 -> 1 (num_1 highest priority).
REQ-018 STAGE_DISPLAY: score cleared to 0 on entry; counts frame_ticks; after SHOW_FRAMES ticks -> GAME_WAIT.
REQ-019 GAME_WAIT: key_touched high -> INGAME next cycle.
REQ-020 INGAME: step counter counts frame_ticks; step=1 for one cycle, coincident with frame_tick, every main_difficulty-th tick; step counter cleared on INGAME entry.
REQ-021 INGAME: good_collision high -> score+1, saturating at 255; one increment per clk cycle asserted.
REQ-022 INGAME: bad_collision high -> GAME_OVER next cycle; bad wins if both high same cycle (no score increment); no step issued that cycle.
REQ-023 GAME_OVER: score frozen; after OVER_FRAMES frame_ticks -> MENU; main_difficulty held until next selection.
REQ-024 esc high in any state other than MENU -> MENU next cycle, overriding all other transitions.
REQ-025 Frame-count-based state timers SHALL clear on every state entry.
REQ-026 Outputs inmenu/stage_show/ingame/game_over SHALL be exactly one-hot and match current state; step SHALL be 0 outside INGAME.
REQ-027 num_x held high through MENU exit SHALL NOT re-latch main_difficulty outside MENU.

Reset
REQ-028 reset high SHALL immediately force MENU, inmenu=1, other state flags 0, step=0, frame_tick=0, frame counter 0, score=0, main_difficulty=1.
REQ-029 reset asserted mid-INGAME SHALL abort the game with the REQ-028 values; first state action after deassertion occurs on the next rising clk edge.

Verification (FRAME_DIV=4, SHOW_FRAMES=2, OVER_FRAMES=3)
REQ-030 Reset, then num_2 pulse 1 cycle -> stage_show=1 next cycle, main_difficulty=3; GAME_WAIT reached after 2 frame_ticks.
REQ-031 num_1 and num_3 high together in MENU -> main_difficulty=10.
REQ-032 In GAME_WAIT, key_touched -> ingame=1; with difficulty 3, step pulses exactly on every 3rd frame_tick (12 clk apart), 1 cycle wide.
REQ-033 INGAME, good_collision for 300 cycles -> score saturates at 255; good and bad same cycle -> score unchanged, game_over=1 next cycle, returns to MENU after 3 frame_ticks.
REQ-034 esc during STAGE_DISPLAY -> inmenu=1 next cycle; reset during INGAME with score=5 -> score=0, inmenu=1 without clk edge.
